// File: rtl/demux_1_4.sv
// demux_1_4: steers each upstream beat to one of four independently buffered downstream lanes.
// Define DEMUX_1_4_TWO_DEEP_EN for 2-entry lane FIFOs; otherwise each lane is a single register slot.
module demux_1_4 #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [WIDTH-1:0]   up_data,
  input  logic [1:0]         up_sel,
  output logic [3:0]         down_valid,
  input  logic [3:0]         down_ready,
  output logic [4*WIDTH-1:0] down_data
);

  // Handshake: a beat moves on an edge where valid && ready on that channel; up_ready looks only
  // at up_sel and registered lane fullness, so it never depends on any down_ready.
  logic [3:0] full;
  logic [3:0] push;
  logic [3:0] pop;

  always_comb begin
    up_ready     = !rst && !full[up_sel];
    push         = 4'b0000;
    push[up_sel] = up_valid && up_ready;
  end

  assign pop = down_valid & down_ready;

  for (genvar i = 0; i < 4; i++) begin : g_lane
`ifdef DEMUX_1_4_TWO_DEEP_EN
    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;

    always_ff @(posedge clk) begin
      if (rst) begin
        mem[0] <= '0;
        mem[1] <= '0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push[i]) begin
          mem[wr_ptr] <= up_data;
          wr_ptr      <= !wr_ptr;
        end
        if (pop[i]) begin
          rd_ptr <= !rd_ptr;
        end
        count <= count + {1'b0, push[i]} - {1'b0, pop[i]};
      end
    end

    assign full[i]                     = count[1];
    assign down_valid[i]               = (count != 2'd0);
    assign down_data[i*WIDTH +: WIDTH] = mem[rd_ptr];
`else
    logic [WIDTH-1:0] slot;
    logic             occupied;

    // A full slot refuses writes, so push and pop never coincide on one lane here.
    always_ff @(posedge clk) begin
      if (rst) begin
        slot     <= '0;
        occupied <= 1'b0;
      end else begin
        if (push[i]) begin
          slot     <= up_data;
          occupied <= 1'b1;
        end else if (pop[i]) begin
          occupied <= 1'b0;
        end
      end
    end

    assign full[i]                     = occupied;
    assign down_valid[i]               = occupied;
    assign down_data[i*WIDTH +: WIDTH] = slot;
`endif
  end

endmodule
